vin_bus_sequencer: RTL and testbench

Internal-bus master for the VIN side of the EF9340/EF9341 pair. It generates the four bus-cycle types the GEN responds to: type 1 code load, type 2 slice read, type 3 mailbox drain and type 4 mailbox load. It drives `sm_n`, `sg_n`, `st_n`, `r_wi` and `adr`, and shares `busA`/`busB` with the GEN. The display fetch logic and the command executor upstream issue requests through ready/valid-style handshakes, and this block serialises them onto the single bus.

---
 rtl/vin_bus_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_vin_bus_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vin_bus_sequencer.sv
// rtl/vin_bus_sequencer.sv - VIN-side internal bus master generating GEN bus cycles types 1-4
module vin_bus_sequencer #(
  parameter int T_SETUP  = 2,
  parameter int T_STROBE = 4,
  parameter int T_HOLD   = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_cell_req,
  input  logic [7:0] i_cell_a,
  input  logic [7:0] i_cell_b,
  input  logic [3:0] i_cell_slice,
  output logic       o_cell_ready,
  output logic [7:0] o_slice_data,
  output logic       o_slice_valid,
  input  logic       i_ld_req,
  input  logic [7:0] i_ld_a,
  input  logic [7:0] i_ld_b,
  output logic       o_ld_ready,
  input  logic       i_ve_n,
  output logic [7:0] o_mb_a,
  output logic [7:0] o_mb_b,
  output logic       o_mb_valid,
  inout  wire  [7:0] io_bus_a,
  inout  wire  [7:0] io_bus_b,
  output logic       o_r_wi,
  output logic       o_sm_n,
  output logic       o_sg_n,
  output logic       o_st_n,
  output logic [3:0] o_adr
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_t;
  typedef enum logic [1:0] {CT_T1, CT_T2, CT_T3, CT_T4} ctype_t;

  localparam logic [7:0] LP_SETUP_LAST  = 8'(T_SETUP - 1);
  localparam logic [7:0] LP_STROBE_LAST = 8'(T_STROBE - 1);
  localparam logic [7:0] LP_HOLD_LAST   = 8'(T_HOLD - 1);

  state_t     r_state, w_state_nxt;
  ctype_t     r_ctype, w_ctype_nxt;
  logic [7:0] r_phase, w_phase_nxt;
  logic       w_sel_cell, w_sel_ld, w_sel_ve;
  logic [1:0] r_ve_hold;

  logic [7:0] r_bus_a, r_bus_b;
  logic [3:0] r_slice;

  logic       r_sm_n, r_sg_n, r_st_n, r_r_wi, r_drive, r_ready;
  logic [3:0] r_adr;
  logic       w_sm_n_nxt, w_sg_n_nxt, w_st_n_nxt, w_r_wi_nxt, w_drive_nxt, w_ready_nxt;
  logic [3:0] w_adr_nxt;
  logic       w_active, w_strobe, w_strobe_last;

  logic [7:0] r_slice_data, r_mb_a, r_mb_b;
  logic       r_slice_valid, r_mb_valid;

  assign w_strobe_last = (r_state == S_STROBE) && (r_phase == LP_STROBE_LAST);

  // State register: bus phase, cycle type and clocks spent in the phase
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_ctype <= CT_T1;
      r_phase <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ctype <= w_ctype_nxt;
      r_phase <= w_phase_nxt;
    end
  end

  // Next state: fixed-priority arbitration in IDLE, phase sequencing elsewhere; T1 chains into T2
  always_comb begin
    w_state_nxt = r_state;
    w_ctype_nxt = r_ctype;
    w_phase_nxt = r_phase + 8'd1;
    w_sel_cell  = 1'b0;
    w_sel_ld    = 1'b0;
    w_sel_ve    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_phase_nxt = '0;
        if (i_cell_req) begin
          w_sel_cell  = 1'b1;
          w_state_nxt = S_SETUP;
          w_ctype_nxt = CT_T1;
        end else if (i_ld_req) begin
          w_sel_ld    = 1'b1;
          w_state_nxt = S_SETUP;
          w_ctype_nxt = CT_T4;
        end else if (!i_ve_n && (r_ve_hold == 2'd0)) begin
          w_sel_ve    = 1'b1;
          w_state_nxt = S_SETUP;
          w_ctype_nxt = CT_T3;
        end
      end
      S_SETUP: begin
        if (r_phase == LP_SETUP_LAST) begin
          w_state_nxt = S_STROBE;
          w_phase_nxt = '0;
        end
      end
      S_STROBE: begin
        if (r_phase == LP_STROBE_LAST) begin
          w_state_nxt = S_HOLD;
          w_phase_nxt = '0;
        end
      end
      S_HOLD: begin
        if (r_phase == LP_HOLD_LAST) begin
          w_phase_nxt = '0;
          if (r_ctype == CT_T1) begin
            w_state_nxt = S_SETUP;
            w_ctype_nxt = CT_T2;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_phase_nxt = '0;
      end
    endcase
  end

  // Output decode from the next state so every control line leaves a flop
  always_comb begin
    w_active    = (w_state_nxt != S_IDLE);
    w_strobe    = (w_state_nxt == S_STROBE);
    w_sm_n_nxt  = ~(w_strobe && ((w_ctype_nxt == CT_T1) || (w_ctype_nxt == CT_T4)));
    w_sg_n_nxt  = ~(w_strobe && (w_ctype_nxt == CT_T2));
    w_st_n_nxt  = ~(w_strobe && ((w_ctype_nxt == CT_T3) || (w_ctype_nxt == CT_T4)));
    w_r_wi_nxt  = ~(w_active && (w_ctype_nxt == CT_T3));
    w_drive_nxt = w_active && ((w_ctype_nxt == CT_T1) || (w_ctype_nxt == CT_T4));
    w_ready_nxt = ~w_active;
    w_adr_nxt   = (w_active && (w_ctype_nxt == CT_T2)) ? r_slice : r_adr;
  end

  // Control output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sm_n  <= 1'b1;
      r_sg_n  <= 1'b1;
      r_st_n  <= 1'b1;
      r_r_wi  <= 1'b1;
      r_drive <= 1'b0;
      r_ready <= 1'b1;
      r_adr   <= '0;
    end else begin
      r_sm_n  <= w_sm_n_nxt;
      r_sg_n  <= w_sg_n_nxt;
      r_st_n  <= w_st_n_nxt;
      r_r_wi  <= w_r_wi_nxt;
      r_drive <= w_drive_nxt;
      r_ready <= w_ready_nxt;
      r_adr   <= w_adr_nxt;
    end
  end

  // Request payloads latched at acceptance so requesters may change them afterwards
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bus_a <= '0;
      r_bus_b <= '0;
      r_slice <= '0;
    end else if (w_sel_cell) begin
      r_bus_a <= i_cell_a;
      r_bus_b <= i_cell_b;
      r_slice <= i_cell_slice;
    end else if (w_sel_ld) begin
      r_bus_a <= i_ld_a;
      r_bus_b <= i_ld_b;
    end
  end

  // ve_n hold-off after a drain while the GEN clears its busy flag
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ve_hold <= 2'd0;
    end else if ((r_state == S_HOLD) && (r_phase == LP_HOLD_LAST) && (r_ctype == CT_T3)) begin
      r_ve_hold <= 2'd2;
    end else if ((r_state == S_IDLE) && (r_ve_hold != 2'd0) && !w_sel_ve) begin
      r_ve_hold <= r_ve_hold - 2'd1;
    end
  end

  // Read capture on the last strobe clock of T2 and T3
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_slice_data  <= '0;
      r_slice_valid <= 1'b0;
      r_mb_a        <= '0;
      r_mb_b        <= '0;
      r_mb_valid    <= 1'b0;
    end else begin
      r_slice_valid <= 1'b0;
      r_mb_valid    <= 1'b0;
      if (w_strobe_last && (r_ctype == CT_T2)) begin
        r_slice_data  <= io_bus_a;
        r_slice_valid <= 1'b1;
      end
      if (w_strobe_last && (r_ctype == CT_T3)) begin
        r_mb_a     <= io_bus_a;
        r_mb_b     <= io_bus_b;
        r_mb_valid <= 1'b1;
      end
    end
  end

  assign io_bus_a      = r_drive ? r_bus_a : 8'hzz;
  assign io_bus_b      = r_drive ? r_bus_b : 8'hzz;
  assign o_sm_n        = r_sm_n;
  assign o_sg_n        = r_sg_n;
  assign o_st_n        = r_st_n;
  assign o_r_wi        = r_r_wi;
  assign o_adr         = r_adr;
  assign o_cell_ready  = r_ready;
  assign o_ld_ready    = r_ready & ~i_cell_req;
  assign o_slice_data  = r_slice_data;
  assign o_slice_valid = r_slice_valid;
  assign o_mb_a        = r_mb_a;
  assign o_mb_b        = r_mb_b;
  assign o_mb_valid    = r_mb_valid;

endmodule

// File: tb/tb_vin_bus_sequencer.sv
// tb/tb_vin_bus_sequencer.sv - self-checking bench for vin_bus_sequencer
module tb_vin_bus_sequencer;
  localparam int S = 2;
  localparam int W = 4;
  localparam int H = 2;
  localparam int N = S + W + H;
  localparam int TMAX = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cell_req = 1'b0;
  logic [7:0] cell_a = '0, cell_b = '0;
  logic [3:0] cell_slice = '0;
  logic ld_req = 1'b0;
  logic [7:0] ld_a = '0, ld_b = '0;
  logic ve_n = 1'b1;
  wire cell_ready, ld_ready, slice_valid, mb_valid, r_wi, sm_n, sg_n, st_n;
  wire [7:0] slice_data, mb_a, mb_b;
  wire [3:0] adr;
  wire [7:0] bus_a, bus_b;

  // GEN bus model: returns slice data during sg_n, mailbox during read strobe; park drives 0
  logic [7:0] gen_slice = '0, gen_a = '0, gen_b = '0;
  logic park = 1'b0;
  wire rd_slice = !sg_n;
  wire rd_mb = !r_wi && !st_n;
  wire en_a = park | rd_slice | rd_mb;
  wire en_b = park | rd_mb;
  wire [7:0] val_a = park ? 8'h00 : (rd_slice ? gen_slice : gen_a);
  wire [7:0] val_b = park ? 8'h00 : gen_b;
  assign bus_a = en_a ? val_a : 8'hzz;
  assign bus_b = en_b ? val_b : 8'hzz;

  vin_bus_sequencer #(.T_SETUP(S), .T_STROBE(W), .T_HOLD(H)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cell_req(cell_req), .i_cell_a(cell_a), .i_cell_b(cell_b), .i_cell_slice(cell_slice),
    .o_cell_ready(cell_ready), .o_slice_data(slice_data), .o_slice_valid(slice_valid),
    .i_ld_req(ld_req), .i_ld_a(ld_a), .i_ld_b(ld_b), .o_ld_ready(ld_ready),
    .i_ve_n(ve_n), .o_mb_a(mb_a), .o_mb_b(mb_b), .o_mb_valid(mb_valid),
    .io_bus_a(bus_a), .io_bus_b(bus_b),
    .o_r_wi(r_wi), .o_sm_n(sm_n), .o_sg_n(sg_n), .o_st_n(st_n), .o_adr(adr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic tr_sm [TMAX];
  logic tr_sg [TMAX];
  logic tr_st [TMAX];
  logic tr_rw [TMAX];
  logic tr_sv [TMAX];
  logic tr_mv [TMAX];
  logic tr_cr [TMAX];
  logic tr_lr [TMAX];
  logic [7:0] tr_ba [TMAX];
  logic [7:0] tr_bb [TMAX];
  logic [3:0] tr_adr [TMAX];
  int ld_acc_k;
  logic auto_ve = 1'b0;

  // Runs n clock edges (edge k is the k-th posedge), completing handshakes and recording
  // the outputs at the negedge that follows each edge.
  task automatic run_trace(input int n);
    int drain_low;
    logic c_acc, l_acc;
    drain_low = 0;
    ld_acc_k = -1;
    for (int k = 0; k < n; k++) begin
      c_acc = cell_req & cell_ready;
      l_acc = ld_req & ld_ready;
      @(posedge clk);
      #1;
      if (c_acc) cell_req = 1'b0;
      if (l_acc) begin
        ld_req = 1'b0;
        ld_acc_k = k;
      end
      @(negedge clk);
      tr_sm[k] = sm_n; tr_sg[k] = sg_n; tr_st[k] = st_n; tr_rw[k] = r_wi;
      tr_sv[k] = slice_valid; tr_mv[k] = mb_valid; tr_cr[k] = cell_ready; tr_lr[k] = ld_ready;
      tr_ba[k] = bus_a; tr_bb[k] = bus_b; tr_adr[k] = adr;
      if (!st_n && !r_wi) drain_low++;
      else drain_low = 0;
      if (auto_ve && drain_low == 2) ve_n = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    logic [7:0] got;
    @(negedge clk);
    got = {sm_n, sg_n, st_n, r_wi, slice_valid, mb_valid, cell_ready, ld_ready};
    checks++;
    if (got !== 8'b1111_0011) begin errors++; $display("FAIL reset_ctrl got=%b exp=%b", got, 8'b1111_0011); end
    checks++;
    if ({adr, slice_data, mb_a, mb_b} !== 28'h0) begin
      errors++; $display("FAIL reset_data adr=%h slice=%h mb=%h/%h exp=0", adr, slice_data, mb_a, mb_b);
    end
    park = 1'b1; #1;
    checks++;
    if ({bus_a, bus_b} !== 16'h0000) begin errors++; $display("FAIL reset_bus got=%h/%h exp=released", bus_a, bus_b); end
    park = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_cell(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sl, input logic [7:0] sd);
    logic [5:0] got, exp;
    @(negedge clk);
    cell_a = a; cell_b = b; cell_slice = sl; gen_slice = sd; cell_req = 1'b1;
    #1;
    checks++;
    if (cell_ready !== 1'b1) begin errors++; $display("FAIL cell_ready_idle got=%b exp=1", cell_ready); end
    run_trace(2 * N + 2);
    for (int k = 0; k < 2 * N + 2; k++) begin
      got = {tr_sm[k], tr_sg[k], tr_st[k], tr_rw[k], tr_sv[k], tr_cr[k]};
      exp = {!(k >= S && k < S + W), !(k >= N + S && k < N + S + W), 1'b1, 1'b1,
             (k == N + S + W), (k >= 2 * N)};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL cell_ctrl k=%0d got=%b exp=%b (sm sg st rw sv cr)", k, got, exp); end
      if (k < N) begin
        checks++;
        if ({tr_ba[k], tr_bb[k]} !== {a, b}) begin
          errors++; $display("FAIL cell_bus k=%0d got=%h/%h exp=%h/%h", k, tr_ba[k], tr_bb[k], a, b);
        end
      end else if (k < 2 * N) begin
        checks++;
        if (tr_adr[k] !== sl) begin errors++; $display("FAIL cell_adr k=%0d got=%h exp=%h", k, tr_adr[k], sl); end
      end
    end
    checks++;
    if (slice_data !== sd) begin errors++; $display("FAIL cell_slice_data got=%h exp=%h", slice_data, sd); end
  endtask

  task automatic test_drain(input logic [7:0] da, input logic [7:0] db);
    logic [4:0] got, exp;
    @(negedge clk);
    gen_a = da; gen_b = db; auto_ve = 1'b1; ve_n = 1'b0;
    run_trace(2 * N + 4);
    auto_ve = 1'b0; ve_n = 1'b1;
    for (int k = 0; k < 2 * N + 4; k++) begin
      got = {tr_st[k], tr_rw[k], tr_sm[k], tr_sg[k], tr_mv[k]};
      exp = {!(k >= S && k < S + W), !(k < N), 1'b1, 1'b1, (k == S + W)};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL drain_ctrl k=%0d got=%b exp=%b (st rw sm sg mv)", k, got, exp); end
    end
    checks++;
    if ({mb_a, mb_b} !== {da, db}) begin errors++; $display("FAIL drain_data got=%h/%h exp=%h/%h", mb_a, mb_b, da, db); end
  endtask

  task automatic test_load(input logic [7:0] a, input logic [7:0] b);
    logic [5:0] got, exp;
    @(negedge clk);
    ld_a = a; ld_b = b; ld_req = 1'b1;
    #1;
    checks++;
    if (ld_ready !== 1'b1) begin errors++; $display("FAIL ld_ready_idle got=%b exp=1", ld_ready); end
    run_trace(N + 2);
    for (int k = 0; k < N + 2; k++) begin
      got = {tr_sm[k], tr_st[k], tr_sg[k], tr_rw[k], tr_lr[k], tr_cr[k]};
      exp = {!(k >= S && k < S + W), !(k >= S && k < S + W), 1'b1, 1'b1, (k >= N), (k >= N)};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL load_ctrl k=%0d got=%b exp=%b (sm st sg rw lr cr)", k, got, exp); end
      if (k < N) begin
        checks++;
        if ({tr_ba[k], tr_bb[k]} !== {a, b}) begin
          errors++; $display("FAIL load_bus k=%0d got=%h/%h exp=%h/%h", k, tr_ba[k], tr_bb[k], a, b);
        end
      end
    end
  endtask

  task automatic test_reset_async;
    logic [7:0] got;
    @(negedge clk);
    ld_a = 8'($urandom_range(1, 255)); ld_b = 8'($urandom_range(1, 255)); ld_req = 1'b1;
    run_trace(S + 1);
    checks++;
    if (tr_sm[S] !== 1'b0) begin errors++; $display("FAIL rst_async_pre sm_n got=%b exp=0", tr_sm[S]); end
    #2 rst_n = 1'b0;
    #1 park = 1'b1;
    #1;
    got = {sm_n, sg_n, st_n, r_wi, slice_valid, mb_valid, cell_ready, ld_ready};
    checks++;
    if (got !== 8'b1111_0011) begin errors++; $display("FAIL rst_async_ctrl got=%b exp=%b", got, 8'b1111_0011); end
    checks++;
    if ({adr, slice_data, mb_a, mb_b} !== 28'h0) begin
      errors++; $display("FAIL rst_async_data adr=%h slice=%h mb=%h/%h exp=0", adr, slice_data, mb_a, mb_b);
    end
    checks++;
    if ({bus_a, bus_b} !== 16'h0000) begin errors++; $display("FAIL rst_async_bus got=%h/%h exp=released", bus_a, bus_b); end
    park = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset_t2;
    int pulses;
    @(negedge clk);
    cell_a = 8'($urandom); cell_b = 8'($urandom); cell_slice = 4'($urandom_range(1, 15));
    gen_slice = 8'($urandom_range(1, 255)); cell_req = 1'b1;
    run_trace(N + S + 1);
    checks++;
    if (tr_sg[N + S] !== 1'b0) begin errors++; $display("FAIL rst_t2_pre sg_n got=%b exp=0", tr_sg[N + S]); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({sg_n, slice_valid, cell_ready} !== 3'b101) begin
      errors++; $display("FAIL rst_t2_now got=%b exp=101 (sg sv cr)", {sg_n, slice_valid, cell_ready});
    end
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (slice_valid) pulses++;
    end
    checks++;
    if (pulses != 0 || slice_data !== 8'h00) begin
      errors++; $display("FAIL rst_t2_after pulses=%0d data=%h exp=0/00", pulses, slice_data);
    end
  endtask

  task automatic test_simultaneous;
    int kinds[$], times[$];
    int exp_kind[4], exp_t[4];
    int kd;
    logic [7:0] sd, ma, mbv;
    exp_kind[0] = 1; exp_kind[1] = 2; exp_kind[2] = 4; exp_kind[3] = 3;
    exp_t[0] = S; exp_t[1] = N + S; exp_t[2] = 2 * N + 1 + S; exp_t[3] = 3 * N + 2 + S;
    sd = 8'($urandom); ma = 8'($urandom); mbv = 8'($urandom);
    @(negedge clk);
    cell_a = 8'($urandom); cell_b = 8'($urandom); cell_slice = 4'($urandom);
    ld_a = 8'($urandom); ld_b = 8'($urandom);
    gen_slice = sd; gen_a = ma; gen_b = mbv;
    cell_req = 1'b1; ld_req = 1'b1; ve_n = 1'b0; auto_ve = 1'b1;
    #1;
    checks++;
    if ({cell_ready, ld_ready} !== 2'b10) begin
      errors++; $display("FAIL sim_ready got=%b exp=10 (cell ld)", {cell_ready, ld_ready});
    end
    run_trace(4 * N + 4);
    auto_ve = 1'b0; ve_n = 1'b1;
    for (int k = 0; k < 4 * N + 4; k++) begin
      if ((!tr_sm[k] || !tr_sg[k] || !tr_st[k]) &&
          (k == 0 || (tr_sm[k - 1] && tr_sg[k - 1] && tr_st[k - 1]))) begin
        if (!tr_sm[k] && !tr_st[k]) kd = 4;
        else if (!tr_sm[k]) kd = 1;
        else if (!tr_sg[k]) kd = 2;
        else if (!tr_rw[k]) kd = 3;
        else kd = 0;
        kinds.push_back(kd);
        times.push_back(k);
      end
    end
    checks++;
    if (kinds.size() != 4) begin
      errors++; $display("FAIL sim_count got=%0d exp=4", kinds.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (kinds[i] != exp_kind[i] || times[i] != exp_t[i]) begin
          errors++; $display("FAIL sim_order i=%0d got=T%0d@%0d exp=T%0d@%0d", i, kinds[i], times[i], exp_kind[i], exp_t[i]);
        end
      end
    end
    checks++;
    if (ld_acc_k != 2 * N + 1) begin errors++; $display("FAIL sim_ld_accept got=%0d exp=%0d", ld_acc_k, 2 * N + 1); end
    checks++;
    if ({slice_data, mb_a, mb_b} !== {sd, ma, mbv}) begin
      errors++; $display("FAIL sim_data got=%h/%h/%h exp=%h/%h/%h", slice_data, mb_a, mb_b, sd, ma, mbv);
    end
  endtask

  task automatic test_ve_holdoff;
    int falls[$];
    int pulses;
    @(negedge clk);
    gen_a = 8'($urandom); gen_b = 8'($urandom); ve_n = 1'b0; auto_ve = 1'b0;
    run_trace(2 * N + 4);
    ve_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 2 * N + 4; k++) begin
      if (!tr_st[k] && (k == 0 || tr_st[k - 1])) falls.push_back(k);
      if (tr_mv[k]) pulses++;
    end
    checks++;
    if (falls.size() != 2 || pulses != 2) begin
      errors++; $display("FAIL holdoff_count falls=%0d pulses=%0d exp=2/2", falls.size(), pulses);
    end else begin
      checks++;
      if (falls[0] != S || falls[1] != N + 3 + S) begin
        errors++; $display("FAIL holdoff_time got=%0d,%0d exp=%0d,%0d", falls[0], falls[1], S, N + 3 + S);
      end
    end
  endtask

  task automatic test_random;
    int sel;
    for (int i = 0; i < 8; i++) begin
      sel = $urandom_range(0, 2);
      case (sel)
        0: test_cell(8'($urandom), 8'($urandom), 4'($urandom), 8'($urandom));
        1: test_load(8'($urandom), 8'($urandom));
        default: test_drain(8'($urandom), 8'($urandom));
      endcase
      idle(4);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    test_reset;
    idle(2);
    test_cell(8'h00, 8'h41, 4'd3, 8'h5A);
    idle(3);
    test_drain(8'h12, 8'h34);
    idle(4);
    test_load(8'hA5, 8'h3C);
    idle(3);
    test_reset_async;
    idle(2);
    test_simultaneous;
    idle(4);
    test_reset_t2;
    test_cell(8'($urandom), 8'($urandom), 4'($urandom), 8'($urandom));
    idle(3);
    test_ve_holdoff;
    idle(5);
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
